// File: rtl/hamming_pkg.sv
// Constants and state type shared by the Hamming link transmitter and the
// receive-side sync detector / decoder.
package hamming_pkg;
  localparam logic [3:0] PREAMBLE  = 4'b1001;
  localparam int         FRAME_LEN = 11;
  localparam int         CW_LEN    = 7;

  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} tx_state_t;
endpackage

// File: rtl/hamming74_enc.sv
// Combinational Hamming(7,4) encoder; cw[6] (p1) is the first bit on the line.
module hamming74_enc
  import hamming_pkg::*;
(
  input  logic [3:0]        din,
  output logic [CW_LEN-1:0] cw
);
  logic w_d1, w_d2, w_d3, w_d4;
  logic w_p1, w_p2, w_p4;

  assign w_d1 = din[3];
  assign w_d2 = din[2];
  assign w_d3 = din[1];
  assign w_d4 = din[0];

  assign w_p1 = w_d1 ^ w_d2 ^ w_d4;
  assign w_p2 = w_d1 ^ w_d3 ^ w_d4;
  assign w_p4 = w_d2 ^ w_d3 ^ w_d4;

  assign cw = {w_p1, w_p2, w_d1, w_p4, w_d2, w_d3, w_d4};
endmodule

// File: rtl/hamming_frame_tx.sv
// Serial transmitter: accepts a nibble, sends preamble 1001 plus the Hamming(7,4)
// codeword MSB-first on tx, then holds the line low for GAP_CYCLES.
module hamming_frame_tx
  import hamming_pkg::*;
#(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       tx,
  output logic       tx_active,
  output logic       frame_done
);
  localparam logic [3:0] PRE_LAST = 4'd3;
  localparam logic [3:0] BIT_LAST = 4'(FRAME_LEN - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  tx_state_t              r_state, w_next;
  logic [FRAME_LEN-1:0]   r_sr;
  logic [3:0]             r_bit_cnt, r_gap_cnt;
  logic                   r_tx, r_tx_active, r_frame_done;
  logic [CW_LEN-1:0]      w_cw;
  logic [FRAME_LEN-1:0]   w_frame;
  logic                   w_hs;

  hamming74_enc u_enc (
    .din (din),
    .cw  (w_cw)
  );

  assign w_frame    = {PREAMBLE, w_cw};
  assign din_ready  = (r_state == IDLE);
  assign w_hs       = din_valid && din_ready;
  assign tx         = r_tx;
  assign tx_active  = r_tx_active;
  assign frame_done = r_frame_done;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (din_valid)               w_next = PRE;
      PRE:     if (r_bit_cnt == PRE_LAST)   w_next = DATA;
      DATA:    if (r_bit_cnt == BIT_LAST)   w_next = GAP;
      GAP:     if (r_gap_cnt == GAP_LAST)   w_next = IDLE;
      default:                              w_next = IDLE;
    endcase
  end

  // Bit k of the frame is driven onto r_tx at the edge where r_bit_cnt becomes k,
  // so the first preamble bit appears right at the handshake edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr         <= '0;
      r_bit_cnt    <= '0;
      r_gap_cnt    <= '0;
      r_tx         <= 1'b0;
      r_tx_active  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_frame_done <= 1'b0;
          if (w_hs) begin
            r_tx        <= w_frame[FRAME_LEN-1];
            r_sr        <= {w_frame[FRAME_LEN-2:0], 1'b0};
            r_bit_cnt   <= '0;
            r_tx_active <= 1'b1;
          end else begin
            r_tx        <= 1'b0;
            r_tx_active <= 1'b0;
          end
        end
        PRE, DATA: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_tx         <= 1'b0;
            r_tx_active  <= 1'b0;
            r_frame_done <= 1'b0;
            r_gap_cnt    <= '0;
          end else begin
            r_tx         <= r_sr[FRAME_LEN-1];
            r_sr         <= {r_sr[FRAME_LEN-2:0], 1'b0};
            r_bit_cnt    <= r_bit_cnt + 4'd1;
            r_tx_active  <= 1'b1;
            r_frame_done <= (r_bit_cnt == BIT_LAST - 4'd1);
          end
        end
        GAP: begin
          r_tx         <= 1'b0;
          r_tx_active  <= 1'b0;
          r_frame_done <= 1'b0;
          if (r_gap_cnt != 4'hF) r_gap_cnt <= r_gap_cnt + 4'd1;
        end
        default: begin
          r_tx         <= 1'b0;
          r_tx_active  <= 1'b0;
          r_frame_done <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hamming_frame_tx.sv
// Directed bench for hamming_frame_tx with hand-computed frame bit patterns.
module tb_hamming_frame_tx;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       tx;
  logic       tx_active;
  logic       frame_done;

  int checks = 0;
  int errors = 0;

  // Frames as 11-bit words, bit 10 sent first.
  localparam logic [10:0] F1011 = 11'b1001_0110011;
  localparam logic [10:0] F0000 = 11'b1001_0000000;
  localparam logic [10:0] F1111 = 11'b1001_1111111;
  localparam logic [10:0] F0110 = 11'b1001_1100110;
  localparam logic [10:0] F0101 = 11'b1001_0100101;

  hamming_frame_tx #(.GAP_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .tx         (tx),
    .tx_active  (tx_active),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk); #1;
  endtask

  // Handshake from IDLE; returns with preamble bit 0 on tx.
  task automatic handshake(input logic [3:0] d);
    din       = d;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  // Samples 11 consecutive cycles starting at the current one; optionally
  // scrambles din/din_valid while doing so.
  task automatic capture_frame(input bit scramble, output logic [10:0] bits,
                               output logic [10:0] dn, output logic [10:0] act,
                               output logic [10:0] rdy);
    for (int k = 0; k < 11; k++) begin
      bits[10-k] = tx;
      dn[10-k]   = frame_done;
      act[10-k]  = tx_active;
      rdy[10-k]  = din_ready;
      if (scramble) begin
        din       = 4'(k * 5 + 3);
        din_valid = k[0];
      end
      if (k < 10) step();
    end
  endtask

  task automatic wait_idle;
    int n = 0;
    while (din_ready !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (din_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: din_ready=%b after %0d cycles, required 1", din_ready, n);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; din = 4'h0; din_valid = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if ({tx, tx_active, frame_done, din_ready} !== 4'b0001) begin
        errors++;
        $display("FAIL reset_state cyc%0d: {tx,act,done,rdy}=%b required 0001", c,
                 {tx, tx_active, frame_done, din_ready});
      end
      step();
    end
  endtask

  task automatic test_single_frame;
    logic [10:0] b, dn, act, rdy;
    handshake(4'b1011);
    capture_frame(1'b0, b, dn, act, rdy);
    checks++;
    if (b !== F1011) begin errors++; $display("FAIL single_bits: got %b required %b", b, F1011); end
    checks++;
    if (dn !== 11'b00000000001) begin errors++; $display("FAIL single_done: got %b required 00000000001", dn); end
    checks++;
    if (act !== 11'h7FF || rdy !== 11'h000) begin
      errors++; $display("FAIL single_act_rdy: act=%b rdy=%b required all 1 / all 0", act, rdy);
    end
    for (int g = 0; g < 2; g++) begin
      step();
      checks++;
      if ({tx, tx_active, frame_done, din_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL single_gap%0d: {tx,act,done,rdy}=%b required 0000", g,
                 {tx, tx_active, frame_done, din_ready});
      end
    end
    step();
    checks++;
    if (din_ready !== 1'b1 || tx !== 1'b0) begin
      errors++; $display("FAIL single_idle: rdy=%b tx=%b required 1/0", din_ready, tx);
    end
  endtask

  task automatic test_corner;
    logic [10:0] b, dn, act, rdy;
    logic [3:0]  nib [2]  = '{4'b0000, 4'b1111};
    logic [10:0] want [2] = '{F0000, F1111};
    for (int i = 0; i < 2; i++) begin
      handshake(nib[i]);
      capture_frame(1'b0, b, dn, act, rdy);
      checks++;
      if (b !== want[i]) begin errors++; $display("FAIL corner_bits din=%b: got %b required %b", nib[i], b, want[i]); end
      checks++;
      if (dn !== 11'b00000000001) begin errors++; $display("FAIL corner_done din=%b: got %b required 00000000001", nib[i], dn); end
      step();
      wait_idle();
    end
  endtask

  task automatic test_back_to_back;
    int          hs_cyc[$];
    int          det[$];
    int          last_hs = -100;
    int          lock = 0;
    int          idx;
    logic [3:0]  win = 4'b0000;
    logic [10:0] exp = '0;
    logic        rdy;
    din = 4'b1011; din_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      rdy = din_ready;
      step();
      if (rdy) begin
        hs_cyc.push_back(c);
        last_hs = c;
        exp = (din == 4'b1011) ? F1011 : F0000;
        din = (din == 4'b1011) ? 4'b0000 : 4'b1011;
      end
      if (c - last_hs <= 10) begin
        idx = 10 - (c - last_hs);
        checks++;
        if (tx !== exp[idx]) begin
          errors++; $display("FAIL b2b_bit cyc%0d k%0d: tx=%b required %b", c, c - last_hs, tx, exp[idx]);
        end
      end
      win = {win[2:0], tx};
      if (lock > 0) lock--;
      else if (win == 4'b1001) begin det.push_back(c); lock = 7; end
    end
    din_valid = 1'b0;
    checks++;
    if (hs_cyc.size() != 5) begin errors++; $display("FAIL b2b_hs_count: got %0d required 5", hs_cyc.size()); end
    for (int i = 1; i < hs_cyc.size(); i++) begin
      checks++;
      if (hs_cyc[i] - hs_cyc[i-1] != 14) begin
        errors++; $display("FAIL b2b_spacing %0d: got %0d required 14", i, hs_cyc[i] - hs_cyc[i-1]);
      end
    end
    checks++;
    if (det.size() != hs_cyc.size()) begin
      errors++; $display("FAIL b2b_detect_count: got %0d required %0d", det.size(), hs_cyc.size());
    end
    for (int i = 0; i < det.size() && i < hs_cyc.size(); i++) begin
      checks++;
      if (det[i] != hs_cyc[i] + 3) begin
        errors++; $display("FAIL b2b_detect_pos %0d: got cyc %0d required %0d", i, det[i], hs_cyc[i] + 3);
      end
    end
    wait_idle();
  endtask

  task automatic test_reset_midframe;
    logic [10:0] b, dn, act, rdy;
    handshake(4'b1011);
    repeat (6) step();
    checks++;
    if (tx !== F1011[4]) begin errors++; $display("FAIL midrst_pre: tx=%b required %b", tx, F1011[4]); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({tx, tx_active, frame_done, din_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_state: {tx,act,done,rdy}=%b required 0001", {tx, tx_active, frame_done, din_ready});
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (frame_done !== 1'b0 || tx !== 1'b0) begin
        errors++; $display("FAIL midrst_quiet cyc%0d: done=%b tx=%b required 0/0", c, frame_done, tx);
      end
    end
    handshake(4'b0110);
    capture_frame(1'b0, b, dn, act, rdy);
    checks++;
    if (b !== F0110) begin errors++; $display("FAIL midrst_newframe: got %b required %b", b, F0110); end
    checks++;
    if (dn !== 11'b00000000001) begin errors++; $display("FAIL midrst_done: got %b required 00000000001", dn); end
    step();
    wait_idle();
  endtask

  task automatic test_ignored_input;
    logic [10:0] b, dn, act, rdy;
    handshake(4'b0101);
    capture_frame(1'b1, b, dn, act, rdy);
    checks++;
    if (b !== F0101) begin errors++; $display("FAIL ignore_bits: got %b required %b", b, F0101); end
    checks++;
    if (rdy !== 11'h000 || act !== 11'h7FF) begin
      errors++; $display("FAIL ignore_rdy_act: rdy=%b act=%b required all 0 / all 1", rdy, act);
    end
    for (int g = 0; g < 2; g++) begin
      din = ~din; din_valid = 1'b1;
      step();
      checks++;
      if (din_ready !== 1'b0 || tx_active !== 1'b0 || tx !== 1'b0) begin
        errors++; $display("FAIL ignore_gap%0d: rdy=%b act=%b tx=%b required 0/0/0", g, din_ready, tx_active, tx);
      end
    end
    din_valid = 1'b0;
    step();
    checks++;
    if (din_ready !== 1'b1 || tx_active !== 1'b0) begin
      errors++; $display("FAIL ignore_idle: rdy=%b act=%b required 1/0", din_ready, tx_active);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_corner();
    test_back_to_back();
    test_reset_midframe();
    test_ignored_input();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hamming_frame_tx.md
# hamming_frame_tx

Serial frame transmitter for the protected Hamming link. It accepts a 4-bit nibble over a valid/ready handshake, encodes it as Hamming(7,4), and shifts out an 11-bit frame: the sync preamble `1001` followed by the 7-bit codeword. It drives the serial line `x` that feeds the link-side `1001` sync detector and Hamming decoder. The line idles low between frames.

## Interface
- `GAP_CYCLES`, default 2: idle-low cycles forced after each frame before `din_ready` re-asserts; legal range 1..15.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `din`  in  4  data nibble; `din[3]`=d1, `din[2]`=d2, `din[1]`=d3, `din[0]`=d4.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  transmitter can accept a nibble this cycle.
- `tx`  out  1  serial line, registered.
- `tx_active`  out  1  high while a preamble or codeword bit is on `tx`.
- `frame_done`  out  1  one-cycle pulse, coincident with the last codeword bit on `tx`.

## Operation
- **States:** `IDLE`, `PRE`, `DATA`, `GAP`.
- **IDLE:** `tx`=0 and `din_ready`=1. A handshake occurs when `din_valid && din_ready` at a rising edge. On the handshake, latch the encoded 11-bit frame into the shift register, clear `bit_cnt`, and go to `PRE`.
- **Encoding:**
  - p1 = d1^d2^d4
  - p2 = d1^d3^d4
  - p4 = d2^d3^d4
  - Codeword order on the line: p1, p2, d1, p4, d2, d3, d4.
- **PRE:** emits 1, 0, 0, 1, then goes to `DATA`.
- **DATA:** emits the 7 codeword bits. On the 7th bit, `frame_done`=1. Then go to `GAP`, or to `IDLE` is never taken directly.
- **GAP:** `tx`=0, `din_ready`=0 for `GAP_CYCLES` cycles, then go to `IDLE`.
- **Counters:**
  - `bit_cnt` is 4 bits and counts 0..10 across `PRE`+`DATA`. It saturates and is never allowed to wrap.
  - `gap_cnt` is 4 bits.
- **Data capture:** `din` is sampled only at the handshake edge. Changes to `din` or `din_valid` outside `IDLE` are ignored. `din_valid` held high continuously yields back-to-back frames separated by exactly `GAP_CYCLES` zeros plus the one `IDLE` cycle.
- **Reset:**
  - `rst` has priority over everything, including mid-frame. The frame is abandoned, not completed.
  - Next state is `IDLE`, with `tx`=0, `tx_active`=0, `frame_done`=0, `din_ready`=1 (combinational from state, so `din_ready` is high in the first cycle after reset).
  - The shift register and counters clear to 0.

## Timing
- **Reset values:** `tx`=0, `tx_active`=0, `frame_done`=0, `din_ready`=1.
- **Latency:** handshake at edge E means the first preamble bit (1) is on `tx` from E until E+1. Frame bit k (k=0..10) is valid between edges E+k and E+k+1.
- **Frame length:** `tx_active` is high for exactly 11 consecutive cycles per frame.
- **`frame_done`:** high only during bit 10.
- **Throughput:** the minimum handshake-to-handshake spacing is 11 + `GAP_CYCLES` + 1 cycles. This is 14 with the default.
- **Outputs:**
  - `tx`, `tx_active` and `frame_done` are flops.
  - `din_ready` is decoded from state only, never from `din_valid`. There is no combinational valid-to-ready path.
- **Receiver sync:** the `GAP` zeros guarantee that the receive-side `1001` detector has returned to its idle state before the next preamble.

## Structure
- **Shared package `hamming_pkg`:**
  - `PREAMBLE` = 4'b1001
  - `FRAME_LEN` = 11
  - `CW_LEN` = 7
  - state enum `tx_state_t` {`IDLE`, `PRE`, `DATA`, `GAP`}
  - These constants are shared with the receive-side detector and decoder.
- **Sub-module `hamming74_enc`:** purely combinational. Maps `din[3:0]` to `cw[6:0]`, with `cw[6]`=p1 transmitted first. It is reused by the encoder path.
- **`hamming_frame_tx` contents:** the FSM, the 11-bit left-shifting register (MSB goes out on `tx`), and both counters.

## Test plan
- **Reset state:** assert `rst` for 2 cycles, then release with `din_valid`=0. Expect `tx`=0, `tx_active`=0, `frame_done`=0 and `din_ready`=1 for 20 cycles.
- **Single frame:** `din`=4'b1011, one-cycle valid. `tx` must carry 1,0,0,1,0,1,1,0,0,1,1 on consecutive cycles. `frame_done` is high only on the 11th bit. Then 2 zero cycles with `din_ready`=0, then `din_ready`=1.
- **Corner values:** `din`=4'b0000 gives frame 1,0,0,1,0,0,0,0,0,0,0. `din`=4'b1111 gives 1,0,0,1,1,1,1,1,1,1,1.
- **Back-to-back:** `din_valid` held high with `din` alternating 4'b1011 and 4'b0000. Handshakes must occur exactly 14 cycles apart. The `1001` receive detector fires once per frame, at preamble bit 3.
- **Reset mid-frame:** assert `rst` during codeword bit 2. The next cycle must show `tx`=0 and `din_ready`=1, with no `frame_done` pulse. A new handshake then produces a complete correct frame.
- **Ignored input:** toggle `din` and `din_valid` during `PRE`/`DATA`/`GAP`. There must be no extra handshake, and the transmitted codeword must match the nibble latched at the handshake.
